// File: rtl/alu_input_sequencer.sv
// alu_input_sequencer: debounced A/B/opcode operand entry from a shared switch bus.
// Define SHOW_TIMEOUT_EN to leave S_SHOW automatically after TIMEOUT idle cycles.
module alu_input_sequencer #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       opcode,
  output logic             enable,
  output logic [1:0]       state_o,
  output logic             load_ack
);
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_SHOW = 2'd3} state_t;
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             en_q, en_d, ack_q, ack_d;
  logic             ld_s1_q, ld_s2_q, cl_s1_q, cl_s2_q;
  logic             db_level_q, db_level_d, db_dly_q;
  logic [CW-1:0]    db_cnt_q, db_cnt_d;
  logic             press, db_done;
`ifdef SHOW_TIMEOUT_EN
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
`endif
  // Any sample agreeing with the current level restarts the stability count.
  assign db_done = (ld_s2_q != db_level_q) && (db_cnt_q == CW'(DB_CYCLES - 1));
  assign press   = db_level_q & ~db_dly_q;
  always_comb begin
    db_cnt_d   = (ld_s2_q == db_level_q || db_done) ? '0 : db_cnt_q + 1'b1;
    db_level_d = db_done ? ld_s2_q : db_level_q;
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    ack_d      = 1'b0;
    if (cl_s2_q) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else if (press) begin
      case (state_q)
        S_A:     begin a_d  = data_in;      state_d = S_B;    ack_d = 1'b1; end
        S_B:     begin b_d  = data_in;      state_d = S_OP;   ack_d = 1'b1; end
        S_OP:    begin op_d = data_in[1:0]; state_d = S_SHOW; ack_d = 1'b1; end
        default: state_d = S_A;
      endcase
    end
`ifdef SHOW_TIMEOUT_EN
    else if (state_q == S_SHOW && tmr_q == TW'(TIMEOUT - 1)) state_d = S_A;
    tmr_d = (state_q == S_SHOW && state_d == S_SHOW) ? tmr_q + 1'b1 : '0;
`endif
    en_d = state_d == S_SHOW;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_s1_q    <= 1'b0;
      ld_s2_q    <= 1'b0;
      cl_s1_q    <= 1'b0;
      cl_s2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_dly_q   <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
`ifdef SHOW_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      ld_s1_q    <= btn_load;
      ld_s2_q    <= ld_s1_q;
      cl_s1_q    <= btn_clear;
      cl_s2_q    <= cl_s1_q;
      db_level_q <= db_level_d;
      db_dly_q   <= db_level_q;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
`ifdef SHOW_TIMEOUT_EN
      tmr_q      <= tmr_d;
`endif
    end
  assign A        = a_q;
  assign B        = b_q;
  assign opcode   = op_q;
  assign enable   = en_q;
  assign state_o  = state_q;
  assign load_ack = ack_q;
endmodule

// File: tb/tb_alu_input_sequencer.sv
// tb_alu_input_sequencer: scoreboard bench for the operand-entry sequencer.
module tb_alu_input_sequencer;
  logic       clk = 1'b0, rst = 1'b1, btn_load = 1'b0, btn_clear = 1'b0;
  logic [3:0] data_in = '0, A, B;
  logic [1:0] opcode, state_o;
  logic       enable, load_ack;
  int         vectors = 0, miscompares = 0, acks = 0, pushes = 0;
  logic [9:0] sb[$];
  logic [3:0] ea = '0, eb = '0;
  logic [1:0] eo = '0, es = '0;
  always #5 clk = ~clk;
  alu_input_sequencer dut (
    .clk(clk), .rst(rst), .data_in(data_in), .btn_load(btn_load), .btn_clear(btn_clear),
    .A(A), .B(B), .opcode(opcode), .enable(enable), .state_o(state_o), .load_ack(load_ack)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && load_ack) begin
      acks++;
      if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
      else check("capture", 32'({A, B, opcode}), 32'(sb.pop_front()));
    end
  task automatic model_press(input logic [3:0] d);
    case (es)
      2'd0: begin ea = d; es = 2'd1; end
      2'd1: begin eb = d; es = 2'd2; end
      2'd2: begin eo = d[1:0]; es = 2'd3; end
      default: es = 2'd0;
    endcase
    if (es != 2'd0) begin
      sb.push_back({ea, eb, eo});
      pushes++;
    end
  endtask
  task automatic model_clear();
    es = '0; ea = '0; eb = '0; eo = '0;
  endtask
  task automatic check_regs(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'(es));
    check({tag, "_enable"}, 32'(enable), 32'(es == 2'd3));
    check({tag, "_abop"}, 32'({A, B, opcode}), 32'({ea, eb, eo}));
  endtask
  task automatic press(input logic [3:0] d);
    data_in = d;
    model_press(d);
    btn_load = 1'b1;
    repeat (7) @(negedge clk);
    btn_load = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic clear();
    btn_clear = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_pre", 32'(state_o), 32'(es));
    @(negedge clk);
    model_clear();
    check_regs("clr_edge3");
    btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int n, k;
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset_ack", 32'(load_ack), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    // first capture must land on the 7th edge after the button is sampled
    data_in = 4'd9;
    model_press(4'd9);
    btn_load = 1'b1;
    repeat (6) @(negedge clk);
    check("lat_pre", 32'(state_o), 32'd0);
    @(negedge clk);
    check("lat_edge7", 32'(state_o), 32'd1);
    check("lat_ack", 32'(load_ack), 32'd1);
    btn_load = 1'b0;
    repeat (8) @(negedge clk);
    press(4'd3);
    press(4'b1110);
    check_regs("full_entry");
    check("entry_acks", 32'(acks), 32'd3);
    press(4'd7);
    check_regs("wrap");
    check("wrap_acks", 32'(acks), 32'd3);
    data_in = 4'hF;
    repeat (5) @(negedge clk);
    check_regs("data_idle");
    // bounce: 3 high, 1 low, 2 high is never stable long enough
    data_in = 4'hC;
    btn_load = 1'b1; repeat (3) @(negedge clk);
    btn_load = 1'b0; @(negedge clk);
    btn_load = 1'b1; repeat (2) @(negedge clk);
    btn_load = 1'b0; repeat (20) @(negedge clk);
    check_regs("bounce");
    check("bounce_acks", 32'(acks), 32'd3);
    model_press(4'hC);
    btn_load = 1'b1; repeat (40) @(negedge clk);
    btn_load = 1'b0; repeat (10) @(negedge clk);
    check_regs("held");
    check("held_acks", 32'(acks), 32'd4);
    press(4'd6);
    check_regs("to_op");
    // clear lands on the same edge as the debounced press
    data_in = 4'd1;
    btn_load = 1'b1;
    repeat (4) @(negedge clk);
    btn_clear = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    check_regs("clr_prio");
    check("clr_prio_ack", 32'(load_ack), 32'd0);
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (12) @(negedge clk);
    check_regs("clr_prio_after");
    check("clr_prio_acks", 32'(acks), 32'd5);
    press(4'd2);
    press(4'd8);
    data_in = 4'd1;
    model_press(4'd1);
    btn_load = 1'b1;
    n = 0;
    while (!enable && n < 20) begin @(negedge clk); n++; end
    check("show_rise", 32'(enable), 32'd1);
    btn_load = 1'b0;
    k = 0;
    while (enable && k < 1000) begin @(negedge clk); k++; end
`ifdef SHOW_TIMEOUT_EN
    check("show_timeout", 32'(k), 32'd16);
    es = 2'd0;
`else
    check("show_hold", 32'(k), 32'd1000);
`endif
    check_regs("show_end");
    clear();
    press(4'd5);
    check_regs("pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_regs("async_rst");
    check("async_rst_ack", 32'(load_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("ack_total", 32'(acks), 32'(pushes));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
